encode_8: RTL and testbench

- Sequential 8-to-3 request encoder; the encode direction paired with the existing 3-to-8 one-hot decoder.
- Collects eight request lines into a sticky pending register and emits one 3-bit index at a time over a valid/ready handshake.
- Selection is fixed-priority or round-robin.
- Sits between interrupt/event sources and any consumer that expects binary indices, such as a dispatcher or a decode_3 driving a one-hot select.

---
 rtl/encode_8_pkg.sv | 19 +
 rtl/encode_8_sel.sv | 28 ++
 rtl/encode_8.sv | 98 +++++++++
 tb/tb_encode_8.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encode_8_pkg.sv
// Shared widths, state encoding and one-hot helper for the 8-to-3 request encoder.
package encode_8_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned REQ_N = 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [REQ_N-1:0] req_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic req_t idx_onehot(input idx_t idx);
    return req_t'(1) << idx;
  endfunction

endpackage

// File: rtl/encode_8_sel.sv
// First set bit at or after base_i, wrapping from the top index back to 0.
// With base_i tied to zero this is a plain lowest-index priority selector.
module prio_sel_8
  import encode_8_pkg::*;
(
  input  logic [REQ_N-1:0] vec_i,
  input  logic [IDX_W-1:0] base_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      // 3-bit add wraps naturally, giving the circular search order
      cand = base_i + IDX_W'(i);
      if (!found_o && vec_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/encode_8.sv
// Sequential 8-to-3 request encoder: sticky pending register, fixed-priority or
// round-robin selection, one binary index per valid/ready transfer.
module encode_8
  import encode_8_pkg::*;
#(
  parameter bit RR_MODE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [REQ_N-1:0] req_i,
  input  logic             flush_i,
  output logic [IDX_W-1:0] code_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [REQ_N-1:0] pending_o,
  output logic             merge_o
);

  state_e state_q, state_d;
  req_t   pending_q, pending_d;
  req_t   grant_mask, presented_mask;
  idx_t   code_q, code_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   sel_base, sel_idx;
  logic   sel_found;
  logic   merge_q, merge_d;
  logic   grant;

  assign sel_base = RR_MODE ? rr_ptr_q : '0;

  prio_sel_8 u_sel (
    .vec_i   (pending_q),
    .base_i  (sel_base),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    rr_ptr_d = rr_ptr_q;
    grant    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (sel_found) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    grant_mask = grant ? idx_onehot(sel_idx) : '0;
    if (grant) begin
      code_d   = sel_idx;
      rr_ptr_d = sel_idx + idx_t'(1);
    end

    pending_d = flush_i ? req_i : ((pending_q & ~grant_mask) | req_i);

    // The presented-but-unaccepted index no longer sits in pending, so it is
    // added explicitly: a fresh request on it counts as a merge.
    presented_mask = (state_q == HOLD) ? idx_onehot(code_q) : '0;
    merge_d        = |(req_i & (pending_q | grant_mask | presented_mask));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      rr_ptr_q  <= '0;
      merge_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      rr_ptr_q  <= rr_ptr_d;
      merge_q   <= merge_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = (state_q == HOLD);
  assign pending_o = pending_q;
  assign merge_o   = merge_q;

endmodule

// File: tb/tb_encode_8.sv
// Scoreboard bench for encode_8: a fixed-priority and a round-robin instance
// share stimulus and are compared against a behavioural model.
module tb_encode_8;

  logic       clk_i;
  logic       rst_n_i;
  logic [7:0] req_i;
  logic       flush_i;
  logic       ready_i;

  logic [2:0] code_f, code_r;
  logic       valid_f, valid_r;
  logic [7:0] pend_f, pend_r;
  logic       merge_f, merge_r;

  encode_8 #(.RR_MODE(1'b0)) dut_fp (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .flush_i(flush_i),
    .code_o(code_f), .valid_o(valid_f), .ready_i(ready_i),
    .pending_o(pend_f), .merge_o(merge_f)
  );

  encode_8 #(.RR_MODE(1'b1)) dut_rr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .flush_i(flush_i),
    .code_o(code_r), .valid_o(valid_r), .ready_i(ready_i),
    .pending_o(pend_r), .merge_o(merge_r)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // behavioural model, index 0 = fixed priority, 1 = round robin
  logic [7:0]  m_pend  [2];
  logic        m_valid [2];
  int unsigned m_code  [2];
  int unsigned m_ptr   [2];
  logic        m_merge [2];
  int unsigned exp_f[$], exp_r[$];
  int unsigned log_f[$], log_r[$];

  logic        pv [2];
  logic [2:0]  pc [2];
  logic        prdy;

  function automatic void chk(input string nm, input int m,
                              input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, m, act, exp, $time);
    end
  endfunction

  task automatic model_reset(input int m);
    m_pend[m]  = '0;
    m_valid[m] = 1'b0;
    m_code[m]  = 0;
    m_ptr[m]   = 0;
    m_merge[m] = 1'b0;
    if (m == 0) exp_f.delete(); else exp_r.delete();
  endtask

  task automatic model_step(input int m, input logic [7:0] r, input logic rdy, input logic fl);
    logic [7:0]  gbit, pres;
    logic [2:0]  ix;
    int unsigned base, pick;
    bit          found;
    gbit  = '0;
    found = 0;
    pick  = 0;
    pres  = m_valid[m] ? (8'b1 << m_code[m]) : 8'b0;
    if (!m_valid[m] || rdy) begin
      base = (m == 1) ? m_ptr[m] : 0;
      for (int k = 0; k < 8; k++) begin
        ix = 3'((base + k) % 8);
        if (!found && m_pend[m][ix]) begin
          found = 1;
          pick  = (base + k) % 8;
        end
      end
      if (found) begin
        ix         = 3'(pick);
        gbit[ix]   = 1'b1;
        m_code[m]  = pick;
        m_valid[m] = 1'b1;
        m_ptr[m]   = (pick + 1) % 8;
        if (m == 0) exp_f.push_back(pick); else exp_r.push_back(pick);
      end else begin
        m_valid[m] = 1'b0;
      end
    end
    m_merge[m] = |(r & (m_pend[m] | gbit | pres));
    m_pend[m]  = fl ? r : ((m_pend[m] & ~gbit) | r);
  endtask

  task automatic cycle(input logic [7:0] r, input logic rdy, input logic fl);
    req_i   = r;
    ready_i = rdy;
    flush_i = fl;
    @(posedge clk_i);
    if (!rst_n_i) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, r, rdy, fl);
      model_step(1, r, rdy, fl);
    end
    #1;
  endtask

  task automatic mon(input int m, input logic v, input logic [2:0] c,
                     input logic [7:0] p, input logic mg);
    int unsigned e;
    chk("valid", m, v, m_valid[m]);
    chk("pending", m, p, m_pend[m]);
    chk("merge", m, mg, m_merge[m]);
    if (pv[m] && !prdy) begin
      chk("hold_valid", m, v, 1);
      chk("hold_code", m, c, pc[m]);
    end
    if (v && ready_i) begin
      n_cmp++;
      if ((m == 0 && exp_f.size() == 0) || (m == 1 && exp_r.size() == 0)) begin
        n_err++;
        $display("FAIL accept_unexpected dut%0d: got code %0d, expected no transfer at %0t", m, c, $time);
      end else begin
        e = (m == 0) ? exp_f.pop_front() : exp_r.pop_front();
        n_cmp--;
        chk("accepted_code", m, c, e);
      end
      if (m == 0) log_f.push_back(c); else log_r.push_back(c);
    end
    pv[m] = v;
    pc[m] = c;
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      mon(0, valid_f, code_f, pend_f, merge_f);
      mon(1, valid_r, code_r, pend_r, merge_r);
      prdy = ready_i;
    end else begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      prdy  = 1'b1;
    end
  end

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int unsigned want [4];
    logic [7:0] r;
    rst_n_i = 1'b0;
    req_i   = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0; prdy = 1'b1;
    model_reset(0);
    model_reset(1);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    rst_n_i = 1'b1;

    chk("rst_code", 0, code_f, 0);
    chk("rst_valid", 0, valid_f, 0);
    chk("rst_pending", 1, pend_r, 0);

    // single request, two-cycle latency
    log_f.delete();
    cycle(8'h10, 1'b1, 1'b0);
    drain(4);
    chk("basic_count", 0, log_f.size(), 1);
    if (log_f.size() >= 1) chk("basic_code", 0, log_f[0], 4);

    // fixed-priority drain order
    log_f.delete();
    cycle(8'hA5, 1'b1, 1'b0);
    drain(6);
    want = '{0, 2, 5, 7};
    chk("fp_count", 0, log_f.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_f.size()) chk("fp_order", 0, log_f[i], want[i]);

    // backpressure
    cycle(8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, 1'b0);
    chk("bp_code", 0, code_f, 1);
    drain(4);

    // round-robin fairness with requests held
    log_r.delete();
    for (int i = 0; i < 12; i++) cycle(8'h81, 1'b1, 1'b0);
    drain(5);
    for (int i = 1; i < log_r.size(); i++)
      chk("rr_alternate", 1, (log_r[i] != log_r[i-1]) ? 1 : 0, 1);
    chk("rr_enough", 1, (log_r.size() >= 10) ? 1 : 0, 1);

    // merge while presented and unaccepted
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("merge_repend", 0, pend_f[3], 1);
    drain(4);

    // flush does not retract the presented code
    cycle(8'hF0, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b0);
    chk("flush_pending", 0, pend_f, 0);
    chk("flush_valid", 0, valid_f, 1);
    drain(3);

    // asynchronous reset in HOLD
    cycle(8'h30, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("pre_rst_valid", 0, valid_f, 1);
    chk("pre_rst_code", 0, code_f, 4);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 0, valid_f, 0);
    chk("arst_code", 0, code_f, 0);
    chk("arst_pending", 0, pend_f, 0);
    chk("arst_valid", 1, valid_r, 0);
    chk("arst_pending", 1, pend_r, 0);
    model_reset(0);
    model_reset(1);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    rst_n_i = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cycle(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    drain(20);
    chk("drained_fp", 0, exp_f.size(), 0);
    chk("drained_rr", 1, exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
